// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline constants for the writeback stage: default widths,
// EX_WB field positions (the execute stage packs the bus with the same
// constants) and the halt state encoding.
package writeback_regfile_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_RADDR_W = 5;
  localparam int DEFAULT_BUS_W   = 181;
  localparam int DEFAULT_CNT_W   = 32;

  // ID_EX and EX_WB share one width
  localparam int ID_EX_W = 181;
  localparam int EX_WB_W = 181;

  localparam int WB_DATA_LSB  = 0;
  localparam int WB_DATA_MSB  = 31;
  localparam int WB_ADDR_LSB  = 64;
  localparam int WB_ADDR_MSB  = 68;
  localparam int WB_WE_BIT    = 69;
  localparam int WB_HALT_BIT  = 70;
  localparam int WB_VALID_BIT = 71;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// Execute-to-writeback bus plus decode read ports and commit trace.
// The master side is the pipeline (EX stage / decode), the slave side is
// the writeback register file.
interface writeback_regfile_if
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int RADDR_W = DEFAULT_RADDR_W,
  parameter int BUS_W   = DEFAULT_BUS_W,
  parameter int CNT_W   = DEFAULT_CNT_W
);

  logic [BUS_W-1:0]   EX_WB;
  logic [RADDR_W-1:0] rd_addr_a;
  logic [RADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0]  rd_data_a;
  logic [DATA_W-1:0]  rd_data_b;
  logic               wb_valid;
  logic [RADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               halted;
  logic [CNT_W-1:0]   retired_count;

  modport master (
    output EX_WB, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_valid, wb_addr, wb_data, halted, retired_count
  );

  modport slave (
    input  EX_WB, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_valid, wb_addr, wb_data, halted, retired_count
  );

endinterface

// File: rtl/writeback_regfile_2r1w.sv
// 2^RADDR_W x DATA_W register array with one synchronous write port and two
// combinational read ports. Register 0 reads as zero and is never written;
// a read of the address being written this cycle returns the write data.
module writeback_regfile_2r1w #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [RADDR_W-1:0] raddr_a,
  input  logic [RADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]  rdata_a,
  output logic [DATA_W-1:0]  rdata_b
);

  localparam int DEPTH = 1 << RADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array storage: cleared on reset, written on a qualified write to a nonzero register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Port A: r0 is zero, same-cycle write forwards ahead of the stale array value
  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == '0) begin
      rdata_a = '0;
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  // Port B: identical to port A, bypasses independently
  always_comb begin
    rdata_b = mem[raddr_b];
    if (raddr_b == '0) begin
      rdata_b = '0;
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Final pipeline stage: decodes EX_WB, commits results to the register
// file, counts retired instructions and latches processor halt. Once
// halted only reset brings the stage back; the read ports stay live.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int RADDR_W = DEFAULT_RADDR_W,
  parameter int BUS_W   = DEFAULT_BUS_W,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  writeback_regfile_if.slave bus
);

  logic               ex_valid;
  logic               ex_we;
  logic               ex_halt;
  logic [RADDR_W-1:0] ex_dest;
  logic [DATA_W-1:0]  ex_data;
  logic               unused_ex_bits;

  wb_state_t          state_q;
  wb_state_t          state_d;
  logic               in_run;
  logic               commit;
  logic               retire;

  logic               wb_valid_q;
  logic [RADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic [CNT_W-1:0]   count_q;

  assign ex_data  = bus.EX_WB[WB_DATA_MSB:WB_DATA_LSB];
  assign ex_dest  = bus.EX_WB[WB_ADDR_MSB:WB_ADDR_LSB];
  assign ex_we    = bus.EX_WB[WB_WE_BIT];
  assign ex_halt  = bus.EX_WB[WB_HALT_BIT];
  assign ex_valid = bus.EX_WB[WB_VALID_BIT];

  assign unused_ex_bits = ^{bus.EX_WB[BUS_W-1:WB_VALID_BIT+1],
                            bus.EX_WB[WB_ADDR_LSB-1:WB_DATA_MSB+1]};

  // A write held on the bus while reset is asserted is discarded, so it must
  // not leak through the bypass path either.
  assign in_run = (state_q == RUN);
  assign retire = ex_valid && in_run;
  assign commit = retire && ex_we && !ex_halt && (ex_dest != '0) && !reset;

  // Halt state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a valid halt instruction in RUN parks the stage until reset
  always_comb begin
    state_d = state_q;
    if (in_run && ex_valid && ex_halt) begin
      state_d = HALTED;
    end
  end

  // Commit trace and retired-instruction counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      count_q    <= '0;
    end else begin
      wb_valid_q <= commit;
      if (commit) begin
        wb_addr_q <= ex_dest;
        wb_data_q <= ex_data;
      end
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  writeback_regfile_2r1w #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (commit),
    .waddr   (ex_dest),
    .wdata   (ex_data),
    .raddr_a (bus.rd_addr_a),
    .raddr_b (bus.rd_addr_b),
    .rdata_a (bus.rd_data_a),
    .rdata_b (bus.rd_data_b)
  );

  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_addr       = wb_addr_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.halted        = (state_q == HALTED);
  assign bus.retired_count = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed vector table, hand-written reset
// sequences, then random traffic against an architectural model. A second
// instance with a 2-bit retire counter shares all inputs so counter
// wrap-around is exercised within a short run.
module tb_writeback_regfile;
  import writeback_regfile_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  writeback_regfile_if #(.CNT_W(32)) bus ();
  writeback_regfile_if #(.CNT_W(2))  bus_s ();

  writeback_regfile #(.CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  writeback_regfile #(.CNT_W(2)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s)
  );

  assign bus_s.EX_WB     = bus.EX_WB;
  assign bus_s.rd_addr_a = bus.rd_addr_a;
  assign bus_s.rd_addr_b = bus.rd_addr_b;

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          v;
    bit          we;
    bit          halt;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    bit          exp_wbv;
    logic [4:0]  exp_wba;
    logic [31:0] exp_wbd;
    logic [31:0] exp_cnt;
    bit          exp_halted;
  } vec_t;

  vec_t vecs[11];

  // architectural model
  logic [31:0] m_regs[32];
  bit          m_halted;
  int unsigned m_cnt;
  bit          m_wbv;
  logic [4:0]  m_wba;
  logic [31:0] m_wbd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [180:0] make_ex(input bit v, input bit we, input bit halt,
                                           input logic [4:0] dest, input logic [31:0] data);
    logic [191:0] junk;
    logic [180:0] ex;
    for (int i = 0; i < 6; i++) junk[i*32 +: 32] = $urandom;
    ex = junk[180:0];
    ex[WB_DATA_MSB:WB_DATA_LSB] = data;
    ex[WB_ADDR_MSB:WB_ADDR_LSB] = dest;
    ex[WB_WE_BIT]    = we;
    ex[WB_HALT_BIT]  = halt;
    ex[WB_VALID_BIT] = v;
    return ex;
  endfunction

  task automatic apply_stimulus(input logic [180:0] ex, input logic [4:0] ra, input logic [4:0] rb);
    bus.EX_WB     = ex;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_halted = 0;
    m_cnt    = 0;
    m_wbv    = 0;
    m_wba    = '0;
    m_wbd    = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr, input bit v, input bit we,
                                             input bit halt, input logic [4:0] dest,
                                             input logic [31:0] data);
    if (addr == 0) return 32'h0;
    if (!m_halted && v && we && !halt && dest == addr) return data;
    return m_regs[addr];
  endfunction

  task automatic model_step(input bit v, input bit we, input bit halt,
                            input logic [4:0] dest, input logic [31:0] data);
    m_wbv = 0;
    if (!m_halted && v) begin
      m_cnt++;
      if (halt) begin
        m_halted = 1;
      end else if (we && dest != 0) begin
        m_regs[dest] = data;
        m_wbv = 1;
        m_wba = dest;
        m_wbd = data;
      end
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, "_wb_valid"}, {31'd0, bus.wb_valid}, {31'd0, m_wbv});
    check({tag, "_wb_addr"}, {27'd0, bus.wb_addr}, {27'd0, m_wba});
    check({tag, "_wb_data"}, bus.wb_data, m_wbd);
    check({tag, "_halted"}, {31'd0, bus.halted}, {31'd0, m_halted});
    check({tag, "_count"}, bus.retired_count, m_cnt);
    check({tag, "_count2"}, {30'd0, bus_s.retired_count}, m_cnt % 4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bit          v, we, halt;
    logic [4:0]  dest, ra, rb;
    logic [31:0] data;
    int          halted_cycles;

    vecs[0]  = '{0, 0, 0, 5'd0, 32'h0,        5'd5, 5'd0, 32'h0,        32'h0,        0, 5'd0, 32'h0,        32'd0, 0};
    vecs[1]  = '{1, 1, 0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1, 32'hDEADBEEF, 32'h0,        1, 5'd5, 32'hDEADBEEF, 32'd1, 0};
    vecs[2]  = '{0, 0, 0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5'd5, 32'hDEADBEEF, 32'd1, 0};
    vecs[3]  = '{1, 1, 0, 5'd7, 32'h12345678, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 1, 5'd7, 32'h12345678, 32'd2, 0};
    vecs[4]  = '{1, 1, 0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,        32'h12345678, 0, 5'd7, 32'h12345678, 32'd3, 0};
    vecs[5]  = '{1, 0, 0, 5'd9, 32'h00001111, 5'd9, 5'd5, 32'h0,        32'hDEADBEEF, 0, 5'd7, 32'h12345678, 32'd4, 0};
    vecs[6]  = '{0, 1, 0, 5'd9, 32'h00002222, 5'd9, 5'd9, 32'h0,        32'h0,        0, 5'd7, 32'h12345678, 32'd4, 0};
    vecs[7]  = '{1, 1, 0, 5'd3, 32'h00000001, 5'd3, 5'd7, 32'h1,        32'h12345678, 1, 5'd3, 32'h1,        32'd5, 0};
    vecs[8]  = '{1, 1, 1, 5'd3, 32'h00000099, 5'd3, 5'd3, 32'h1,        32'h1,        0, 5'd3, 32'h1,        32'd6, 1};
    vecs[9]  = '{1, 1, 0, 5'd3, 32'h00000055, 5'd3, 5'd0, 32'h1,        32'h0,        0, 5'd3, 32'h1,        32'd6, 1};
    vecs[10] = '{1, 0, 1, 5'd0, 32'h0,        5'd3, 5'd5, 32'h1,        32'hDEADBEEF, 0, 5'd3, 32'h1,        32'd6, 1};

    // reset then idle
    bus.EX_WB     = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus('0, 5'(i), 5'(31 - i));
      check($sformatf("reset_rd_a_r%0d", i), bus.rd_data_a, 32'h0);
      check($sformatf("reset_rd_b_r%0d", 31 - i), bus.rd_data_b, 32'h0);
    end
    check("reset_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("reset_halted", {31'd0, bus.halted}, 32'd0);
    check("reset_count", bus.retired_count, 32'd0);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(make_ex(vecs[i].v, vecs[i].we, vecs[i].halt, vecs[i].dest, vecs[i].data),
                     vecs[i].ra, vecs[i].rb);
      check($sformatf("row%0d_rd_a", i), bus.rd_data_a, vecs[i].exp_a);
      check($sformatf("row%0d_rd_b", i), bus.rd_data_b, vecs[i].exp_b);
      @(posedge clock);
      #1;
      check($sformatf("row%0d_wb_valid", i), {31'd0, bus.wb_valid}, {31'd0, vecs[i].exp_wbv});
      check($sformatf("row%0d_wb_addr", i), {27'd0, bus.wb_addr}, {27'd0, vecs[i].exp_wba});
      check($sformatf("row%0d_wb_data", i), bus.wb_data, vecs[i].exp_wbd);
      check($sformatf("row%0d_count", i), bus.retired_count, vecs[i].exp_cnt);
      check($sformatf("row%0d_count2", i), {30'd0, bus_s.retired_count}, vecs[i].exp_cnt % 4);
      check($sformatf("row%0d_halted", i), {31'd0, bus.halted}, {31'd0, vecs[i].exp_halted});
      @(negedge clock);
    end

    // reset out of HALTED takes effect without a clock edge
    apply_stimulus('0, 5'd3, 5'd5);
    #1;
    reset = 1'b1;
    #1;
    check("halt_reset_halted", {31'd0, bus.halted}, 32'd0);
    check("halt_reset_count", bus.retired_count, 32'd0);
    check("halt_reset_wb_data", bus.wb_data, 32'h0);
    check("halt_reset_r3", bus.rd_data_a, 32'h0);
    check("halt_reset_r5", bus.rd_data_b, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // async reset while a write to r9 is presented
    apply_stimulus(make_ex(1, 1, 0, 5'd9, 32'hA5A5A5A5), 5'd9, 5'd5);
    check("midwr_bypass", bus.rd_data_a, 32'hA5A5A5A5);
    #1;
    reset = 1'b1;
    #1;
    check("midwr_r9_in_reset", bus.rd_data_a, 32'h0);
    check("midwr_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    @(posedge clock);
    #1;
    check("midwr_r9_after_edge", bus.rd_data_a, 32'h0);
    check("midwr_count", bus.retired_count, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midwr_bypass_after_release", bus.rd_data_a, 32'hA5A5A5A5);
    @(posedge clock);
    #1;
    check("midwr_first_edge_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("midwr_first_edge_addr", {27'd0, bus.wb_addr}, 32'd9);
    check("midwr_first_edge_count", bus.retired_count, 32'd1);
    @(negedge clock);
    apply_stimulus('0, 5'd9, 5'd0);
    check("midwr_r9_committed", bus.rd_data_a, 32'hA5A5A5A5);

    // random traffic against the model
    do_reset();
    model_reset();
    halted_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 1) != 0);
      halt = ($urandom_range(0, 39) == 0);
      dest = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      data = $urandom;
      ra   = ($urandom_range(0, 1) != 0) ? dest : 5'($urandom_range(0, 31));
      rb   = 5'($urandom_range(0, 7));
      apply_stimulus(make_ex(v, we, halt, dest, data), ra, rb);
      check("rand_rd_a", bus.rd_data_a, model_read(ra, v, we, halt, dest, data));
      check("rand_rd_b", bus.rd_data_b, model_read(rb, v, we, halt, dest, data));
      @(posedge clock);
      model_step(v, we, halt, dest, data);
      #1;
      check_output("rand");
      @(negedge clock);
      if (m_halted) halted_cycles++;
      if (halted_cycles > 8) begin
        do_reset();
        model_reset();
        halted_cycles = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Final pipeline stage, directly downstream of the execute stage; consumes the 181-bit EX_WB bus each clock.
- Commits ALU results into a 32 x 32-bit architectural register file and serves two read ports to the decode stage, with same-cycle write bypass.
- Tracks retired instructions and latches processor halt.

Parameters:
- DATA_W, 32, register and result width
- RADDR_W, 5, register address width (2^RADDR_W registers)
- BUS_W, 181, EX_WB bus width
- CNT_W, 32, retired-instruction counter width

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- EX_WB  input  BUS_W  execute-to-writeback bus. Fields:
  - [31:0] result data
  - [68:64] destination register
  - [69] write enable
  - [70] halt
  - [71] valid
  - remaining bits ignored
- rd_addr_a  input  RADDR_W  decode read port A address
- rd_addr_b  input  RADDR_W  decode read port B address
- rd_data_a  output  DATA_W  port A data (combinational)
- rd_data_b  output  DATA_W  port B data (combinational)
- wb_valid  output  1  registered: a write committed last cycle
- wb_addr  output  RADDR_W  registered: address of last committed write
- wb_data  output  DATA_W  registered: data of last committed write
- halted  output  1  registered: processor halted
- retired_count  output  CNT_W  registered: retired-instruction count

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - All 32 registers = 0.
  - wb_valid = 0, wb_addr = 0, wb_data = 0, halted = 0, retired_count = 0.
  - State = RUN.
  - Reset asserted mid-operation discards any in-flight write. The first edge after deassertion samples EX_WB normally.
- Definitions: commit = valid & we & ~halt_bit & (state == RUN) & (dest != 0).
- On a commit edge:
  - reg[dest] <= data.
  - wb_valid <= 1, wb_addr <= dest, wb_data <= data.
  - Otherwise wb_valid <= 0; wb_addr and wb_data hold their previous values.
  - Write latency: 1 edge. A value is architecturally visible after the edge.
- Register 0 is hardwired zero:
  - Reads always return 0.
  - Writes to 0 are dropped and do not assert wb_valid.
  - A write to 0 still counts as retired if valid.
- Read ports:
  - Asynchronous (combinational) from the register array.
  - Bypass: if commit is true this cycle and rd_addr == dest (nonzero), rd_data = incoming EX_WB data, not the stale array value.
  - Ports A and B bypass independently; both may bypass at once.
- Retire counter:
  - Increments by 1 on every edge with valid = 1 while in RUN, including a halt instruction and non-writing instructions (we = 0, e.g. NOP, branches).
  - Wraps modulo 2^CNT_W: 0xFFFFFFFF -> 0x00000000.
  - Frozen in HALTED.
- State machine (2 states):
  - RUN: on valid & halt_bit -> HALTED at that edge. The halt instruction does not write, even if we = 1, and is counted.
  - HALTED: halted = 1. All EX_WB content is ignored: no writes, no counting, wb_valid = 0. Exit only via reset.
  - Read ports remain functional in HALTED, for debug inspection.
- valid = 0: no write, no count, no state change, regardless of the other bits.

Decomposition:
- Shared package (e.g. pipeline_pkg):
  - EX_WB field bit positions: WB_DATA_LSB/MSB, WB_ADDR_LSB/MSB, WB_WE_BIT, WB_HALT_BIT, WB_VALID_BIT.
  - Bus width constants (ID_EX and EX_WB = 181).
  - State encoding: RUN = 1'b0, HALTED = 1'b1.
  - The execute stage uses the same constants when packing EX_WB.
- One natural sub-module: regfile_2r1w.
  - 32 x 32 array, async reset, one synchronous write port, two asynchronous read ports with write bypass, r0 = 0.
  - The top wrapper adds field decode, halt FSM, retire counter and trace registers.

Test Plan:
- Reset then idle: reset pulse, EX_WB = 0 for 5 cycles -> all reads 0, halted = 0, retired_count = 0, wb_valid = 0.
- Basic write: valid, we, dest = 5, data = 0xDEADBEEF -> after the edge rd_data_a(addr 5) = 0xDEADBEEF, wb_valid = 1, wb_addr = 5, retired_count = 1. Next idle cycle -> wb_valid = 0.
- Bypass and r0:
  - Same cycle as a write of 0x12345678 to r7, rd_addr_a = 7 and rd_addr_b = 7 -> both read 0x12345678 before the edge.
  - Write 0xFFFFFFFF to r0 -> r0 reads 0, wb_valid = 0, retired_count increments.
- Halt:
  - Write r3 = 0x1.
  - Then valid | halt | we with dest = 3, data = 0x99 -> r3 stays 0x1, halted = 1, count +1.
  - Subsequent valid writes to r3 = 0x55 -> ignored, count frozen.
  - Reset -> halted = 0, r3 = 0.
- Counter wrap: force retired_count to 0xFFFFFFFE, retire 3 instructions -> count reads 0x00000001.
- Async reset mid-write: assert reset between edges while a write to r9 = 0xA5A5A5A5 is presented -> r9 = 0, outputs cleared immediately without a clock edge.
